// File: rtl/ql_ce_gen_pkg.sv
// Speed encodings and divider-derived limits shared by the clock-enable generator.
// Compile-time constants only; no clocked logic.
package ql_ce_pkg;

  localparam int SPD_X1 = 0;
  localparam int SPD_X2 = 1;
  localparam int SPD_X4 = 2;
  localparam int SPD_X8 = 3;

  // Fastest speed is the one at which every slot of the frame becomes a CPU slot.
  function automatic int maxspd(input int div_w);
    return div_w - 3;
  endfunction

endpackage

// File: rtl/ql_ce_gen_if.sv
// Speed/hold requests in, registered strobes out; all one-clock pulses, no backpressure.
interface ql_ce_gen_if #(
  parameter int SPEED_W = 2
);

  logic [SPEED_W-1:0] speed;
  logic               hold;
  logic               ce_p;
  logic               ce_n;
  logic               ce_vid;
  logic               ce_sd;
  logic               ce_bus_p;
  logic               ce_bus_n;
  logic               cpu_cycle;
  logic               ce_tick;
  logic [SPEED_W-1:0] speed_cur;

  modport master (
    output speed, hold,
    input  ce_p, ce_n, ce_vid, ce_sd, ce_bus_p, ce_bus_n, cpu_cycle, ce_tick, speed_cur
  );

  modport slave (
    input  speed, hold,
    output ce_p, ce_n, ce_vid, ce_sd, ce_bus_p, ce_bus_n, cpu_cycle, ce_tick, speed_cur
  );

endinterface

// File: rtl/ql_tick_gen.sv
// Timebase tick: one-clock pulse, integer period TICK_DIV, or fractional NUM/DEN rate
// when CE_FRAC_EN is defined. Registered output, free-running, no backpressure.
module ql_tick_gen #(
`ifdef CE_FRAC_EN
  parameter int TICK_NUM = 1,
  parameter int TICK_DEN = 640,
  parameter int ACC_W    = 32
`else
  parameter int TICK_DIV = 640
`endif
) (
  input  logic clk_sys,
  input  logic reset,
  output logic ce_tick
);

`ifdef CE_FRAC_EN
  localparam logic [ACC_W-1:0] NUM = ACC_W'(TICK_NUM);
  localparam logic [ACC_W-1:0] DEN = ACC_W'(TICK_DEN);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc + NUM;

  // Wrapping by DEN keeps the remainder, so the long-run rate is exact and jitter is one clock.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc     <= '0;
      ce_tick <= 1'b0;
    end else if (acc_sum >= DEN) begin
      acc     <= acc_sum - DEN;
      ce_tick <= 1'b1;
    end else begin
      acc     <= acc_sum;
      ce_tick <= 1'b0;
    end
  end
`else
  localparam int              CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt     <= '0;
      ce_tick <= 1'b0;
    end else begin
      ce_tick <= (cnt == '0);
      cnt     <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end
`endif

endmodule

// File: rtl/ql_ce_gen.sv
// QL clock-enable generator: bus/video/SD/timebase strobes, one clock after the matching div value.
// Speed applied at frame boundaries, hold at slot starts; free-running, no backpressure. CE_FRAC_EN: fractional tick.
module ql_ce_gen
  import ql_ce_pkg::*;
#(
  parameter int DIV_W    = 5,
  parameter int SPEED_W  = 2,
`ifdef CE_FRAC_EN
  parameter int TICK_NUM = 1,
  parameter int TICK_DEN = 640,
  parameter int ACC_W    = 32
`else
  parameter int TICK_DIV = 640
`endif
) (
  input logic        clk_sys,
  input logic        reset,
  ql_ce_gen_if.slave ce
);

  localparam int                 SLOT_W    = DIV_W - 3;
  localparam int                 NSLOT     = 2 ** SLOT_W;
  localparam logic [SPEED_W-1:0] MAXSPD_V  = SPEED_W'(maxspd(DIV_W));
  localparam logic [SLOT_W-1:0]  SLOT_MASK = SLOT_W'(NSLOT - 1);

  logic [DIV_W-1:0]   div;
  logic [SLOT_W-1:0]  slot;
  logic               at_slot;
  logic               at_frame;
  logic [SPEED_W-1:0] speed_sat;
  logic [SPEED_W-1:0] speed_cur;
  logic [SPEED_W-1:0] speed_cur_d;
  logic               duty;
  logic               duty_d;
  logic               sub_cycle;
  logic               sub_cycle_d;
  logic               ce_p_q;
  logic               ce_n_q;
  logic               ce_sd_q;

  assign slot      = div[DIV_W-1:3];
  assign at_slot   = (div[2:0] == 3'd0);
  assign at_frame  = (div == '0);
  assign speed_sat = (ce.speed > MAXSPD_V) ? MAXSPD_V : ce.speed;

  // The freshly latched speed feeds the duty equation of the same boundary.
  always_comb begin
    speed_cur_d = speed_cur;
    duty_d      = duty;
    sub_cycle_d = sub_cycle;
    if (at_frame) begin
      speed_cur_d = speed_sat;
      sub_cycle_d = (speed_sat == '0) ? !sub_cycle : 1'b1;
    end
    if (at_slot) begin
      duty_d = !ce.hold && ((slot & (SLOT_MASK >> speed_cur_d)) == '0);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div       <= '0;
      speed_cur <= SPEED_W'(SPD_X1);
      duty      <= 1'b0;
      sub_cycle <= 1'b0;
      ce_p_q    <= 1'b0;
      ce_n_q    <= 1'b0;
      ce_sd_q   <= 1'b0;
    end else begin
      div       <= div + DIV_W'(1);
      speed_cur <= speed_cur_d;
      duty      <= duty_d;
      sub_cycle <= sub_cycle_d;
      ce_p_q    <= at_slot;
      ce_n_q    <= (div[2:0] == 3'd4);
      ce_sd_q   <= (div[1:0] == 2'd0);
    end
  end

  // duty only changes on the edge that raises ce_p, so bus strobes are never split within a slot.
  assign ce.ce_p      = ce_p_q;
  assign ce.ce_n      = ce_n_q;
  assign ce.ce_vid    = ce_p_q;
  assign ce.ce_sd     = ce_sd_q;
  assign ce.ce_bus_p  = ce_p_q & duty;
  assign ce.ce_bus_n  = ce_n_q & duty;
  assign ce.cpu_cycle = duty & sub_cycle;
  assign ce.speed_cur = speed_cur;

  ql_tick_gen #(
`ifdef CE_FRAC_EN
    .TICK_NUM (TICK_NUM),
    .TICK_DEN (TICK_DEN),
    .ACC_W    (ACC_W)
`else
    .TICK_DIV (TICK_DIV)
`endif
  ) u_tick (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce_tick (ce.ce_tick)
  );

endmodule

// File: tb/tb_ql_ce_gen.sv
// Scoreboard bench for ql_ce_gen: expected strobe events are queued by the stimulus
// and popped by a monitor whenever ce_p, ce_n or ce_tick fires.
module tb_ql_ce_gen;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  bit   chk_p   = 1'b0;

  typedef struct {
    int cyc;
    int bus;
    int cpu;
    int spd;
  } ev_t;

  ev_t exp_p[$];
  ev_t exp_n[$];
  int  exp_t[$];

  // Hand-derived per-frame expectations for the first run: speed_cur, sub_cycle, duty per slot.
  int f_spd[11]  = '{0, 0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
  int f_sub[11]  = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1};
  int f_duty[11] = '{1, 1, 1, 1, 1, 15, 15, 13, 15, 0, 1};

  ql_ce_gen_if #(.SPEED_W(2)) ce_if ();

  ql_ce_gen #(
    .DIV_W    (5),
    .SPEED_W  (2)
`ifdef CE_FRAC_EN
    , .TICK_NUM (3)
    , .TICK_DEN (2048)
`else
    , .TICK_DIV (640)
`endif
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ce      (ce_if)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, expv, cyc);
  endtask

  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ce_p"}, ce_if.ce_p, 0);
    chk({tag, " ce_n"}, ce_if.ce_n, 0);
    chk({tag, " ce_vid"}, ce_if.ce_vid, 0);
    chk({tag, " ce_sd"}, ce_if.ce_sd, 0);
    chk({tag, " ce_bus_p"}, ce_if.ce_bus_p, 0);
    chk({tag, " ce_bus_n"}, ce_if.ce_bus_n, 0);
    chk({tag, " cpu_cycle"}, ce_if.cpu_cycle, 0);
    chk({tag, " ce_tick"}, ce_if.ce_tick, 0);
    chk({tag, " speed_cur"}, int'(ce_if.speed_cur), 0);
  endtask

  // ce_p of slot s in frame f lands in cycle 32f+8s+1, ce_n four clocks later.
  task automatic push_frames(input int nfr, input int cutoff);
    ev_t e;
    for (int f = 0; f < nfr; f++) begin
      for (int s = 0; s < 4; s++) begin
        e.bus = (f_duty[f] >> s) & 1;
        e.cpu = e.bus & f_sub[f];
        e.spd = f_spd[f];
        e.cyc = 32 * f + 8 * s + 1;
        if (e.cyc <= cutoff) exp_p.push_back(e);
        e.cyc = e.cyc + 4;
        if (e.cyc <= cutoff) exp_n.push_back(e);
      end
    end
  endtask

  always @(negedge clk_sys) begin
    ev_t e;
    if (!reset) begin
      if (ce_if.ce_p && chk_p) begin
        if (exp_p.size() == 0) chk("unexpected ce_p", cyc, -1);
        else begin
          e = exp_p.pop_front();
          chk("ce_p cycle", cyc, e.cyc);
          chk("ce_bus_p", ce_if.ce_bus_p, e.bus);
          chk("cpu_cycle at ce_p", ce_if.cpu_cycle, e.cpu);
          chk("speed_cur", int'(ce_if.speed_cur), e.spd);
          chk("ce_vid", ce_if.ce_vid, 1);
        end
      end
      if (ce_if.ce_n && chk_p) begin
        if (exp_n.size() == 0) chk("unexpected ce_n", cyc, -1);
        else begin
          e = exp_n.pop_front();
          chk("ce_n cycle", cyc, e.cyc);
          chk("ce_bus_n", ce_if.ce_bus_n, e.bus);
          chk("cpu_cycle at ce_n", ce_if.cpu_cycle, e.cpu);
        end
      end
      if (ce_if.ce_bus_p) chk("ce_bus_p without ce_p", ce_if.ce_p, 1);
      if (ce_if.ce_bus_n) chk("ce_bus_n without ce_n", ce_if.ce_n, 1);
      if (ce_if.ce_tick) begin
        if (exp_t.size() == 0) chk("unexpected ce_tick", cyc, -1);
        else chk("ce_tick cycle", cyc, exp_t.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ce_if.speed = 2'd0;
    ce_if.hold  = 1'b0;
    reset       = 1'b1;
    repeat (10) @(posedge clk_sys);
    #1;
    chk_idle("reset");

    push_frames(11, 340);
`ifndef CE_FRAC_EN
    exp_t.push_back(1);
`endif
    chk_p = 1'b1;
    reset = 1'b0;

    for (int k = 1; k <= 9; k++) begin
      goto(k);
      chk("ce_sd early", ce_if.ce_sd, ((k - 1) % 4 == 0) ? 1 : 0);
    end

    goto(141); ce_if.speed = 2'd2;
    goto(227); ce_if.hold  = 1'b1;
    goto(228); ce_if.hold  = 1'b0;
    goto(231); ce_if.hold  = 1'b1;
    goto(234); ce_if.hold  = 1'b0;
    goto(245); ce_if.speed = 2'd3;
    goto(288); ce_if.speed = 2'd0; ce_if.hold = 1'b1;
    goto(289); ce_if.hold  = 1'b0;

    goto(340);
    chk_p = 1'b0;
    reset = 1'b1;
    chk("ce_p events left run1", exp_p.size(), 0);
    chk("ce_n events left run1", exp_n.size(), 0);
    chk("ce_tick events left run1", exp_t.size(), 0);
    repeat (4) @(posedge clk_sys);
    #1;
    chk_idle("mid reset");

    push_frames(2, 64);
`ifdef CE_FRAC_EN
    exp_t.push_back(683);
    exp_t.push_back(1366);
    exp_t.push_back(2048);
`else
    exp_t.push_back(1);
    exp_t.push_back(641);
    exp_t.push_back(1281);
    exp_t.push_back(1921);
`endif
    chk_p = 1'b1;
    reset = 1'b0;
    goto(64);
    chk_p = 1'b0;
    goto(2100);
    chk("ce_p events left run2", exp_p.size(), 0);
    chk("ce_n events left run2", exp_n.size(), 0);
    chk("ce_tick events left run2", exp_t.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ql_ce_gen.md
# ql_ce_gen

Parametrised clock-enable generator for the QL core, producing every bus, video, SD and timebase strobe from the single system clock. It generalises the fixed x1/x2/x4 divider to a configurable slot count and speed range, and adds frame-aligned speed changes, a slot-aligned CPU hold and a programmable timebase tick. It sits beside the PLL in the top level and feeds the CPU enable, SDRAM sync, ZX8301/ZX8302, qlromext and the RTC prescale.

## Interface
- DIV_W, 5: master divider width; slots per frame NSLOT = 2^(DIV_W-3), each slot 8 clocks; legal range 4..8.
- SPEED_W, 2: width of speed request.
- TICK_DIV, 640: integer timebase period in clocks (≥2).
- TICK_NUM, 1: fractional increment (CE_FRAC_EN only).
- TICK_DEN, 640: fractional modulus (CE_FRAC_EN only), TICK_NUM < TICK_DEN.
- ACC_W, 32: fractional accumulator width.

- clk_sys  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- speed  in  SPEED_W  requested speed: 0 = x1, m = x2^m; saturates at MAXSPD = DIV_W-3.
- hold  in  1  request to suppress CPU bus slots.
- ce_p  out  1  bus phase strobe, div[2:0]==0.
- ce_n  out  1  bus phase strobe, div[2:0]==4.
- ce_vid  out  1  pixel strobe, div[2:0]==0, never gated.
- ce_sd  out  1  SD strobe, div[1:0]==0.
- ce_bus_p  out  1  ce_p & duty.
- ce_bus_n  out  1  ce_n & duty.
- cpu_cycle  out  1  duty & sub_cycle.
- ce_tick  out  1  one-clock timebase pulse.
- speed_cur  out  SPEED_W  currently applied, saturated speed.

## Operation
- div: DIV_W-bit free-running up-counter, wraps to 0; never stops while reset is low. slot = div[DIV_W-1:3].
- Frame boundary: div==0. At each boundary, speed_cur <= min(speed, MAXSPD); mid-frame speed changes are ignored until the next boundary.
- duty is updated at every slot start (div[2:0]==0): duty <= !hold_s && ((slot & ((NSLOT-1)>>speed_cur))==0). hold_s is hold sampled at that same instant, so duty is constant for the whole 8-clock slot and ce_bus_p/ce_bus_n are never split.
- sub_cycle is updated at frame boundary: speed_cur==0 → toggle; otherwise forced to 1.
- Effective CPU share: x1 = 1 slot per 2 frames; at MAXSPD every slot.
- Timebase (integer): counter 0..TICK_DIV-1, ce_tick when counter==0; period exactly TICK_DIV.
- Boundary conditions: hold asserted mid-slot takes effect at the next slot; speed and hold changing at the same boundary are both applied, with the new speed_cur used in the duty equation of that boundary; reset mid-frame aborts the frame, and all state returns to reset values.

## Timing
- All outputs are registered: each strobe is high for exactly one clk_sys in the cycle after div held the matching value.
- Reset values: div=0, all strobes 0, duty=0, sub_cycle=0, speed_cur=0, tick counter and accumulator 0.
- First ce_p/ce_vid/ce_sd is in cycle 1 after reset is released. The first ce_bus_p follows one clock after the first boundary.
- Speed latency: ≤ 2^DIV_W clocks after the request, applied from the next frame boundary.
- Hold latency: ≤ 8 clocks.

## Configuration
- CE_FRAC_EN defined: ce_tick comes from a fractional accumulator, acc += TICK_NUM; when acc+TICK_NUM ≥ TICK_DEN the accumulator wraps by subtracting TICK_DEN and ce_tick pulses. Long-run rate is TICK_NUM/TICK_DEN per clock, with jitter ≤1 clock. TICK_DIV is unused.
- CE_FRAC_EN undefined: integer divider only; TICK_NUM, TICK_DEN and ACC_W are unused, with no accumulator logic.

## Structure
- Package ql_ce_pkg: speed constants SPD_X1/SPD_X2/SPD_X4/SPD_X8 and the MAXSPD function of DIV_W.
- Sub-module ql_tick_gen: the timebase (integer or fractional under CE_FRAC_EN), with clk_sys and reset ports and output ce_tick.

## Test plan
- Reset: hold reset 10 clocks → all outputs 0. Release reset → ce_p in cycle 1, ce_n in cycle 5, ce_sd in cycles 1, 5 and 9.
- DIV_W=5, speed=0, hold=0 → cpu_cycle & ce_bus_p exactly once per 64 clocks; ce_bus_p once per 32 clocks.
- speed 0→2 written at div=13 → speed_cur changes at div=0 of the next frame; from then ce_bus_p on every ce_p.
- speed=3 with DIV_W=5 → speed_cur=2 (saturated), behaviour identical to speed=2.
- hold pulsed at div=3 for 1 clock → no effect. hold high across div=8 → slot 1 has no ce_bus_p/ce_bus_n, while ce_vid continues.
- Integer TICK_DIV=640 → ce_tick spacing exactly 640. CE_FRAC_EN, NUM=3, DEN=2048 → 3 ticks per 2048 clocks over 2^16 clocks, spacing 682 or 683.
